// File: rtl/vga_rx_monitor_if.sv
// VGA pixel bus between a VGA controller (master) and a sink such as
// vga_rx_monitor (slave).
//   hs     hsync, active low
//   vs     vsync, active low
//   blank  1 = active pixel, 0 = blanking
//   r/g/b  8-bit colour components
interface vga_rx_monitor_if;
  logic       hs;
  logic       vs;
  logic       blank;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;

  modport master (output hs, vs, blank, r, g, b);
  modport slave  (input  hs, vs, blank, r, g, b);
endinterface

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: sink-side checker for the VGA pixel interface.
// Samples HS/VS/BLANK/RGB, measures line and frame timing against the
// configured mode and reports frame events, sticky timing errors and lock.
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-high
//   vga          vga_rx_monitor_if.slave (hs, vs, blank, r, g, b)
//   clr_err      one-cycle pulse, clears the sticky error flags
//   frame_done   one-cycle pulse per completed frame
//   frame_count  completed frames since reset (wraps)
//   err          sticky: [0] line length, [1] hsync width,
//                [2] active pixels/line, [3] frame lines/active lines
//   locked       last completed frame had no error
//   frame_sig    signature of the last completed frame
//
// Build option: define VGA_RX_MONITOR_CRC_EN to make frame_sig a
// CRC-16-CCITT (poly 0x1021, init 0xFFFF) over the active pixels {R,G,B},
// MSB first. Without it there is no CRC logic and frame_sig is 0.
module vga_rx_monitor #(
  parameter int HDISP  = 800,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VDISP  = 480,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic                   clk,
  input  logic                   reset,
  vga_rx_monitor_if.slave        vga,
  input  logic                   clr_err,
  output logic                   frame_done,
  output logic [15:0]            frame_count,
  output logic [3:0]             err,
  output logic                   locked,
  output logic [15:0]            frame_sig
);

  localparam logic [11:0] HTOTAL_C = 12'(HDISP + HFP + HPULSE + HBP);
  localparam logic [11:0] HPULSE_C = 12'(HPULSE);
  localparam logic [11:0] HDISP_C  = 12'(HDISP);
  localparam logic [10:0] VTOTAL_C = 11'(VDISP + VFP + VPULSE + VBP);
  localparam logic [10:0] VDISP_C  = 11'(VDISP);

  typedef enum logic {SEEK, SYNCED} state_t;

  // Counters stick at all-ones so a runaway line/frame can never wrap
  // back into a value that happens to match the expected total.
  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  state_t      state_q, state_d;
  logic        hs_p0_q, hs_p0_d, hs_p1_q, hs_p1_d;
  logic        vs_p0_q, vs_p0_d, vs_p1_q, vs_p1_d;
  logic        blank_p0_q, blank_p0_d;
  logic        clr_p0_q, clr_p0_d;
  logic        h_seen_q, h_seen_d;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] hs_low_q, hs_low_d;
  logic [11:0] act_cnt_q, act_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [10:0] act_lines_q, act_lines_d;
  logic        frame_err_q, frame_err_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [3:0]  err_q, err_d;
  logic        locked_q, locked_d;

  logic        hs_fall, hs_rise, vs_fall;
  logic        line_chk, frame_end;
  logic [3:0]  new_err;
  logic [11:0] h_cnt_end;
  logic [10:0] v_cnt_line, act_lines_line;

  always_comb begin
    // Stage p0: input register; p1: previous sample for edge detection
    hs_p0_d    = vga.hs;
    vs_p0_d    = vga.vs;
    blank_p0_d = vga.blank;
    clr_p0_d   = clr_err;
    hs_p1_d    = hs_p0_q;
    vs_p1_d    = vs_p0_q;

    hs_fall   = hs_p1_q & ~hs_p0_q;
    hs_rise   = ~hs_p1_q & hs_p0_q;
    vs_fall   = vs_p1_q & ~vs_p0_q;
    // Line checks need a previous hs fall so a line cut short by reset
    // is never measured.
    line_chk  = (state_q == SYNCED) & h_seen_q;
    frame_end = vs_fall & (state_q == SYNCED);
    new_err   = 4'b0000;

    // Line length: h_cnt holds HTOTAL-1 at the next fall for a good line.
    h_cnt_end = sat_inc12(h_cnt_q);
    h_cnt_d   = hs_fall ? 12'd0 : h_cnt_end;
    if (hs_fall && line_chk && (h_cnt_end != HTOTAL_C)) new_err[0] = 1'b1;

    // Sync width: count low cycles including the fall cycle.
    if (hs_fall)       hs_low_d = 12'd1;
    else if (!hs_p0_q) hs_low_d = sat_inc12(hs_low_q);
    else               hs_low_d = hs_low_q;
    if (hs_rise && line_chk && (hs_low_q != HPULSE_C)) new_err[1] = 1'b1;

    // Active pixels: a blank line (count 0) is legal, otherwise exactly HDISP.
    if (hs_fall)         act_cnt_d = {11'd0, blank_p0_q};
    else if (blank_p0_q) act_cnt_d = sat_inc12(act_cnt_q);
    else                 act_cnt_d = act_cnt_q;
    if (hs_fall && line_chk && (act_cnt_q != 12'd0) && (act_cnt_q != HDISP_C))
      new_err[2] = 1'b1;

    // Frame: the line ending on this cycle is folded in before the frame
    // compare, so a coincident hs/vs fall counts the line in the old frame.
    v_cnt_line     = hs_fall ? sat_inc11(v_cnt_q) : v_cnt_q;
    act_lines_line = (hs_fall && (act_cnt_q != 12'd0)) ? sat_inc11(act_lines_q)
                                                        : act_lines_q;
    if (frame_end && ((v_cnt_line != VTOTAL_C) || (act_lines_line != VDISP_C)))
      new_err[3] = 1'b1;
    v_cnt_d     = vs_fall ? 11'd0 : v_cnt_line;
    act_lines_d = vs_fall ? 11'd0 : act_lines_line;

    h_seen_d      = h_seen_q | hs_fall;
    state_d       = vs_fall ? SYNCED : state_q;
    frame_done_d  = frame_end;
    frame_count_d = frame_end ? frame_count_q + 16'd1 : frame_count_q;
    // A fresh error beats a simultaneous clear.
    err_d         = (clr_p0_q ? 4'b0000 : err_q) | new_err;
    locked_d      = frame_end ? ~(frame_err_q | (|new_err)) : locked_q;
    frame_err_d   = vs_fall ? 1'b0 : (frame_err_q | (|new_err));
  end

`ifdef VGA_RX_MONITOR_CRC_EN
  logic [23:0] rgb_p0_q, rgb_p0_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] frame_sig_q, frame_sig_d;

  function automatic logic [15:0] crc_step(input logic [15:0] crc,
                                           input logic [23:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 23; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    rgb_p0_d = {vga.r, vga.g, vga.b};
    // A pixel on the vs-fall cycle belongs to the new frame.
    if (vs_fall)         crc_d = blank_p0_q ? crc_step(16'hFFFF, rgb_p0_q) : 16'hFFFF;
    else if (blank_p0_q) crc_d = crc_step(crc_q, rgb_p0_q);
    else                 crc_d = crc_q;
    frame_sig_d = frame_end ? crc_q : frame_sig_q;
  end

  always_ff @(posedge clk) begin
    rgb_p0_q <= rgb_p0_d;
    crc_q    <= crc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) frame_sig_q <= 16'h0000;
    else       frame_sig_q <= frame_sig_d;
  end

  assign frame_sig = frame_sig_q;
`else
  assign frame_sig = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SEEK;
      hs_p0_q       <= 1'b1;
      hs_p1_q       <= 1'b1;
      vs_p0_q       <= 1'b1;
      vs_p1_q       <= 1'b1;
      blank_p0_q    <= 1'b0;
      clr_p0_q      <= 1'b0;
      h_seen_q      <= 1'b0;
      h_cnt_q       <= 12'd0;
      hs_low_q      <= 12'd0;
      act_cnt_q     <= 12'd0;
      v_cnt_q       <= 11'd0;
      act_lines_q   <= 11'd0;
      frame_err_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
      err_q         <= 4'b0000;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_p0_q       <= hs_p0_d;
      hs_p1_q       <= hs_p1_d;
      vs_p0_q       <= vs_p0_d;
      vs_p1_q       <= vs_p1_d;
      blank_p0_q    <= blank_p0_d;
      clr_p0_q      <= clr_p0_d;
      h_seen_q      <= h_seen_d;
      h_cnt_q       <= h_cnt_d;
      hs_low_q      <= hs_low_d;
      act_cnt_q     <= act_cnt_d;
      v_cnt_q       <= v_cnt_d;
      act_lines_q   <= act_lines_d;
      frame_err_q   <= frame_err_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      err_q         <= err_d;
      locked_q      <= locked_d;
    end
  end

  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign err         = err_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor using a reduced video mode so whole frames are short.
// Frames are described by a table of records (line faults, clears, reset,
// pixel pattern, expected err/locked at the frame's completion); the bench
// keeps its own frame counter and a byte-wise CRC-16-CCITT model of the
// pixels it drives.
`timescale 1ns/1ps
module tb_vga_rx_monitor;
  localparam int HD = 16, HF = 4, HP = 6, HB = 4;
  localparam int VD = 10, VF = 2, VP = 2, VB = 3;
  localparam int VT = VD + VF + VP + VB;
  localparam int NF = 16;

  typedef struct {
    int       start_line;
    int       nlines;
    int       bad_len_line;
    int       bad_pulse_line;
    int       bad_act_line;
    int       pix_mode;      // 0 random, 1 all zero, 2 all ones
    int       clr_line;
    int       clr_off;
    int       rst_line;
    bit       chk;           // a frame_done is expected for this frame
    logic [3:0] exp_err;
    bit       exp_locked;
  } frame_vec_t;

  typedef struct {
    logic [3:0]  err;
    bit          locked;
    logic [15:0] count;
    logic [15:0] sig;
    int          vs_cyc;
  } done_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clr_err = 1'b0;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [3:0]  err;
  logic        locked;
  logic [15:0] frame_sig;

  vga_rx_monitor_if vif();

  vga_rx_monitor #(
    .HDISP(HD), .HFP(HF), .HPULSE(HP), .HBP(HB),
    .VDISP(VD), .VFP(VF), .VPULSE(VP), .VBP(VB)
  ) dut (
    .clk(clk), .reset(reset), .vga(vif), .clr_err(clr_err),
    .frame_done(frame_done), .frame_count(frame_count), .err(err),
    .locked(locked), .frame_sig(frame_sig)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  done_exp_t expq[$];
  int rst_chk_cyc = -1;

  bit          pend_valid = 1'b0;
  done_exp_t   pend;
  int          exp_count = 0;
  frame_vec_t  tbl [NF];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [23:0] px);
    logic [15:0] r;
    r = c;
    for (int k = 2; k >= 0; k--) begin
      r = r ^ {px[k*8 +: 8], 8'h00};
      for (int j = 0; j < 8; j++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  function automatic frame_vec_t mk(input int start_line, input int nlines,
      input int bl, input int bp, input int ba, input int pix,
      input int cl, input int co, input int rl, input bit chk,
      input logic [3:0] e, input bit lk);
    frame_vec_t v;
    v.start_line = start_line; v.nlines = nlines;
    v.bad_len_line = bl; v.bad_pulse_line = bp; v.bad_act_line = ba;
    v.pix_mode = pix; v.clr_line = cl; v.clr_off = co; v.rst_line = rl;
    v.chk = chk; v.exp_err = e; v.exp_locked = lk;
    return v;
  endfunction

  // Output checks: every frame_done against the expectation queue, and the
  // cycle right after a mid-frame reset.
  always @(negedge clk) begin
    done_exp_t e;
    if (frame_done) begin
      if (expq.size() == 0) check("unexpected_frame_done", 32'd1, 32'd0);
      else begin
        e = expq.pop_front();
        check("done_latency", cyc, e.vs_cyc + 2);
        check("err_at_done", {28'd0, err}, {28'd0, e.err});
        check("locked_at_done", {31'd0, locked}, {31'd0, e.locked});
        check("frame_count", {16'd0, frame_count}, {16'd0, e.count});
        check("frame_sig", {16'd0, frame_sig}, {16'd0, e.sig});
      end
    end
    if (cyc == rst_chk_cyc) begin
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_frame_count", {16'd0, frame_count}, 32'd0);
      check("rst_err", {28'd0, err}, 32'd0);
      check("rst_locked", {31'd0, locked}, 32'd0);
      check("rst_frame_sig", {16'd0, frame_sig}, 32'd0);
    end
  end

  task automatic drive_frame(input frame_vec_t v);
    int pw, bp, act, fp;
    bit is_act;
    logic [15:0] crc_m;
    logic [23:0] px;
    crc_m = 16'hFFFF;
    for (int l = v.start_line; l < v.nlines; l++) begin
      pw = HP; bp = HB; act = HD; fp = HF;
      if (l == v.bad_len_line) fp--;
      if (l == v.bad_pulse_line) begin pw--; bp++; end
      if (l == v.bad_act_line) begin act--; fp++; end
      is_act = (l >= VP + VB) && (l < VP + VB + VD);
      for (int x = 0; x < pw + bp + act + fp; x++) begin
        @(posedge clk); #1;
        vif.hs    = (x < pw) ? 1'b0 : 1'b1;
        vif.vs    = (l < VP) ? 1'b0 : 1'b1;
        vif.blank = is_act && (x >= pw + bp) && (x < pw + bp + act);
        px = 24'($urandom);
        if (vif.blank && v.pix_mode == 1) px = 24'h000000;
        if (vif.blank && v.pix_mode == 2) px = 24'hFFFFFF;
        {vif.r, vif.g, vif.b} = px;
        clr_err = (l == v.clr_line) && (x == v.clr_off);
        reset   = (l == v.rst_line) && (x == 0);
        if (l == 0 && x == 0 && pend_valid) begin
          exp_count++;
          pend.count  = 16'(exp_count);
          pend.vs_cyc = cyc;
          expq.push_back(pend);
        end
        if (reset) begin
          exp_count   = 0;
          rst_chk_cyc = cyc + 1;
        end
        if (vif.blank) crc_m = crc_model(crc_m, px);
      end
    end
    pend_valid  = v.chk;
    pend.err    = v.exp_err;
    pend.locked = v.exp_locked;
`ifdef VGA_RX_MONITOR_CRC_EN
    pend.sig = crc_m;
`else
    pend.sig = 16'h0000;
`endif
  endtask

  initial begin
    int wait_cyc;
    //            start nl  blen bpul bact pix clrL clrO rst chk err      lk
    tbl[0]  = mk(8,    VT, -1,  -1,  -1,  0,  -1,  0,  -1, 0,  4'b0000, 0);
    tbl[1]  = mk(0,    VT, -1,  -1,  -1,  0,  -1,  0,  -1, 1,  4'b0000, 1);
    tbl[2]  = mk(0,    VT, -1,  -1,  -1,  0,  -1,  0,  -1, 1,  4'b0000, 1);
    tbl[3]  = mk(0,    VT, $urandom_range(1, 15), -1, -1, 0, -1, 0, -1, 1, 4'b0001, 0);
    tbl[4]  = mk(0,    VT, -1,  -1,  -1,  0,  -1,  0,  -1, 1,  4'b0001, 1);
    tbl[5]  = mk(0,    VT, -1,  $urandom_range(1, 16), -1, 0, 0, 10, -1, 1, 4'b0010, 0);
    tbl[6]  = mk(0,    VT, -1,  -1,  -1,  0,   0, 10,  -1, 1,  4'b0000, 1);
    tbl[7]  = mk(0,    VT, -1,  -1,  $urandom_range(VP+VB, VP+VB+VD-1), 0, -1, 0, -1, 1, 4'b0100, 0);
    tbl[8]  = mk(0,    VT,  3,  -1,  -1,  0,   4,  0,  -1, 1,  4'b0001, 0);
    tbl[9]  = mk(0,  VT-1, -1,  -1,  -1,  0,   0, 10,  -1, 1,  4'b1000, 0);
    tbl[10] = mk(0,    VT, -1,  -1,  -1,  1,   0, 10,  -1, 1,  4'b0000, 1);
    tbl[11] = mk(0,    VT, -1,  -1,  -1,  2,  -1,  0,  -1, 1,  4'b0000, 1);
    tbl[12] = mk(0,    VT, -1,  -1,  -1,  0,  -1,  0,  -1, 1,  4'b0000, 1);
    tbl[13] = mk(0,    VT, -1,  -1,  -1,  0,  -1,  0,   8, 0,  4'b0000, 0);
    tbl[14] = mk(0,    VT, -1,  -1,  -1,  0,  -1,  0,  -1, 1,  4'b0000, 1);
    tbl[15] = mk(0,    VT, -1,  -1,  -1,  0,  -1,  0,  -1, 0,  4'b0000, 0);

    vif.hs = 1'b1; vif.vs = 1'b1; vif.blank = 1'b0;
    vif.r = 8'h00; vif.g = 8'h00; vif.b = 8'h00;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);
    check("reset_frame_count", {16'd0, frame_count}, 32'd0);
    check("reset_err", {28'd0, err}, 32'd0);
    check("reset_locked", {31'd0, locked}, 32'd0);
    check("reset_frame_sig", {16'd0, frame_sig}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < NF; i++) drive_frame(tbl[i]);

    wait_cyc = 0;
    while (expq.size() != 0 && wait_cyc < 100) begin
      @(posedge clk);
      wait_cyc++;
    end
    repeat (10) @(posedge clk);
    check("all_frame_done_seen", expq.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, required finish earlier", cyc);
    $fatal(1);
  end

endmodule
